// File: rtl/display_scan_driver.sv
// Multiplexed 8-digit hex display scanner with frame-aligned shadow capture.
// Define DISPLAY_SCAN_DRIVER_GHOST_BLANK_EN to blank the first quarter of each digit slot.
module display_scan_driver #(
    parameter int unsigned DIV_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp,
    input  logic [7:0]  disp_en,
    input  logic [7:0]  disp_dot,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dot_n
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned N_DIG  = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DATA_W = N_DIG * NIB_W;

    localparam logic [DIV_W-1:0] CNT_MAX   = '1;
    localparam logic [N_DIG-1:0] AN_BLANK  = '1;
    localparam logic [SEG_W-1:0] SEG_BLANK = '1;

    logic [DIV_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shadow_disp;
    logic [N_DIG-1:0]  shadow_en;
    logic [N_DIG-1:0]  shadow_dot;

    logic [NIB_W-1:0]  nib_c;
    logic              blank_c;
    logic              load_c;
    logic [N_DIG-1:0]  an_next_c;
    logic [SEG_W-1:0]  seg_next_c;
    logic              dot_next_c;

    // Active-low segment pattern, bit 0 = a ... bit 6 = g.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] nib);
        case (nib)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Next output pattern from the current slot; only shadow data reaches the pins.
    always_comb begin
        nib_c      = shadow_disp[{idx, 2'b00} +: NIB_W];
        load_c     = (idx == '0) && (cnt == '0);
`ifdef DISPLAY_SCAN_DRIVER_GHOST_BLANK_EN
        blank_c    = !shadow_en[idx] || (cnt < (DIV_W'(1) << (DIV_W - 2)));
`else
        blank_c    = !shadow_en[idx];
`endif
        an_next_c  = AN_BLANK;
        seg_next_c = SEG_BLANK;
        dot_next_c = 1'b1;
        if (!blank_c) begin
            an_next_c  = ~(N_DIG'(1) << idx);
            seg_next_c = hex_to_seg(nib_c);
            dot_next_c = ~shadow_dot[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            shadow_disp <= '0;
            shadow_en   <= '0;
            shadow_dot  <= '0;
            an_n        <= AN_BLANK;
            seg_n       <= SEG_BLANK;
            dot_n       <= 1'b1;
        end else begin
            cnt <= cnt + DIV_W'(1);
            if (cnt == CNT_MAX) begin
                idx <= idx + IDX_W'(1);
            end
            // Frame-aligned capture keeps a whole scan on one consistent snapshot.
            if (load_c) begin
                shadow_disp <= disp;
                shadow_en   <= disp_en;
                shadow_dot  <= disp_dot;
            end
            an_n  <= an_next_c;
            seg_n <= seg_next_c;
            dot_n <= dot_next_c;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver at DIV_W=4 (16-clock slots, 128-clock frames).
module tb_display_scan_driver;

    localparam int unsigned DIV_W = 4;
    localparam int SLOT  = 16;
    localparam int FRAME = 128;
`ifdef DISPLAY_SCAN_DRIVER_GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        int         t;
        string      name;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dot;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] disp = 32'h76543210;
    logic [7:0]  disp_en = 8'hFF;
    logic [7:0]  disp_dot = 8'h04;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dot_n;

    int   t = 0;
    int   base = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t q[$];
    exp_t mon_e;

    display_scan_driver #(.DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .disp     (disp),
        .disp_en  (disp_en),
        .disp_dot (disp_dot),
        .an_n     (an_n),
        .seg_n    (seg_n),
        .dot_n    (dot_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) t <= t + 1;

    // Pop every expectation due at this edge and compare against the pins.
    always @(posedge clk) begin
        #1;
        while (q.size() > 0 && q[0].t <= t) begin
            mon_e = q.pop_front();
            checks++;
            if (mon_e.t != t) begin
                $display("FAIL %s: sample missed, at t=%0d required t=%0d", mon_e.name, t, mon_e.t);
            end else if (an_n !== mon_e.an || seg_n !== mon_e.seg || dot_n !== mon_e.dot) begin
                $display("FAIL %s: an_n=%h seg_n=%b dot_n=%b, required an_n=%h seg_n=%b dot_n=%b",
                         mon_e.name, an_n, seg_n, dot_n, mon_e.an, mon_e.seg, mon_e.dot);
            end else begin
                passes++;
            end
        end
    end

    task automatic push_blank(input int abs_t, input string nm);
        exp_t e;
        e.t = abs_t; e.name = nm; e.an = 8'hFF; e.seg = 7'h7F; e.dot = 1'b1;
        q.push_back(e);
    endtask

    // n counts output edges since reset release; slot = n/16 mod 8, phase = n mod 16.
    task automatic push_exp(input int n, input string nm, input bit on,
                            input logic [3:0] nib, input bit dp);
        exp_t e;
        int   p;
        int   k;
        p = n % SLOT;
        k = (n / SLOT) % 8;
        if (!on || (GHOST && p < 4)) begin
            push_blank(base + n, nm);
        end else begin
            e.t = base + n; e.name = nm;
            e.an = ~(8'(1) << k);
            e.seg = SEG_TBL[nib];
            e.dot = ~dp;
            q.push_back(e);
        end
    endtask

    task automatic wait_n(input int n);
        while (t < base + n) @(negedge clk);
    endtask

    initial begin
        int pl [3];
        int guard;
        pl = '{3, 4, 8};

        // Reset held for three edges.
        push_blank(1, "rst_e1");
        push_blank(2, "rst_e2");
        push_blank(3, "rst_e3");
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        base = t + 1;

        // Frame 1: 76543210, all enabled, dot on digit 2.
        push_exp(0, "f1_rel0_blank", 1'b0, 4'h0, 1'b0);
        push_exp(1, "f1_s0_p1", 1'b1, 4'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 3; i++) begin
                push_exp(k * SLOT + pl[i], $sformatf("f1_s%0d_p%0d", k, pl[i]),
                         1'b1, 4'(k), k == 2);
            end
        end
        push_exp(15, "f1_s0_p15", 1'b1, 4'h0, 1'b0);
        // Re-sort: p15 of slot 0 must precede slot 1 entries.
        q.sort() with (item.t);

        // Frame 2: FEDCBA98, lower four digits enabled.
        for (int k = 0; k < 8; k++)
            push_exp(FRAME + k * SLOT + 8, $sformatf("f2_s%0d", k), k < 4, 4'(8 + k), 1'b0);
        // Frame 3: zeros everywhere; disp changes mid-frame and must not tear.
        for (int k = 0; k < 8; k++)
            push_exp(2 * FRAME + k * SLOT + 8, $sformatf("f3_s%0d", k), 1'b1, 4'h0, 1'b0);
        push_exp(3 * FRAME - 1, "f3_s7_p15", 1'b1, 4'h0, 1'b0);
        // Frame 4: first edge still shows previous shadow, then the 8s.
        push_exp(3 * FRAME, "f4_s0_p0_old", 1'b1, 4'h0, 1'b0);
        push_exp(3 * FRAME + 1, "f4_s0_p1_new", 1'b1, 4'h8, 1'b1);
        for (int k = 0; k < 5; k++)
            push_exp(3 * FRAME + k * SLOT + 8, $sformatf("f4_s%0d", k), 1'b1, 4'h8, k == 0);

        wait_n(60);
        disp = 32'hFEDCBA98; disp_en = 8'h0F; disp_dot = 8'h00;
        wait_n(200);
        disp = 32'h00000000; disp_en = 8'hFF; disp_dot = 8'h00;
        wait_n(2 * FRAME + 3 * SLOT + 2);
        disp = 32'h88888888;
        // Changes landing on the load edge itself must be captured.
        wait_n(3 * FRAME - 1);
        disp_dot = 8'h01;

        // One-clock reset during slot 5 of frame 4, with new data presented.
        wait_n(3 * FRAME + 5 * SLOT + 5);
        rst = 1'b1;
        disp = 32'h13579BDF; disp_en = 8'hFF; disp_dot = 8'h80;
        push_blank(t + 1, "mr_rst_edge");
        @(negedge clk);
        rst  = 1'b0;
        base = t + 1;
        push_exp(0, "mr_rel0_blank", 1'b0, 4'h0, 1'b0);
        for (int k = 0; k < 8; k++)
            push_exp(k * SLOT + 8, $sformatf("mr_s%0d", k), 1'b1, 4'(15 - 2 * k), k == 7);

        guard = 0;
        while (q.size() > 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            $display("FAIL %s: never sampled, required t=%0d", mon_e.name, mon_e.t);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
